l4_cmd_dispatch: RTL and testbench

Multi-channel command/result dispatcher placed between NCH host-side command/result FIFO pairs and the single FIFO-style command/result port of one L4 routing accelerator. It grants the accelerator to one channel per route job and passes that channel's command words through until the job-end opcode. It then returns result words to the same channel until the last-result flag, and re-arbitrates round-robin. It extends the single-channel accelerator top into a shared, parametrised resource with per-channel job accounting and protocol-error detection.

---
 rtl/l4_cmd_dispatch_pkg.sv | 14 +
 rtl/l4_cmd_dispatch_if.sv | 30 +++
 rtl/l4_rr_arbiter.sv | 30 +++
 rtl/l4_cmd_dispatch.sv | 122 ++++++++++++
 tb/tb_l4_cmd_dispatch.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/l4_cmd_dispatch_pkg.sv
// Shared L4 dispatcher declarations: FSM encodings and default opcode/flag positions.
package l4_cmd_dispatch_pkg;

  typedef enum logic [1:0] {
    DISP_IDLE     = 2'd0,
    DISP_STREAM   = 2'd1,
    DISP_WAIT_RES = 2'd2,
    DISP_RSVD     = 2'd3
  } disp_state_e;

  localparam int unsigned L4_END_OPC  = 15;
  localparam int unsigned L4_LAST_BIT = 31;

endpackage

// File: rtl/l4_cmd_dispatch_if.sv
// Host-side FIFO pairs plus the accelerator FIFO port; master is the dispatcher side.
interface l4_cmd_dispatch_if
  import l4_cmd_dispatch_pkg::*;
#(
  parameter int NCH    = 4,
  parameter int DWIDTH = 32
);
  logic [NCH-1:0]        h_cmd_empty;
  logic [NCH*DWIDTH-1:0] h_cmd_in;
  logic [NCH-1:0]        h_cmd_rd;
  logic [NCH-1:0]        h_result_full;
  logic [DWIDTH-1:0]     h_result_out;
  logic [NCH-1:0]        h_result_wr;
  logic                  a_cmd_empty;
  logic [DWIDTH-1:0]     a_cmd_in;
  logic                  a_cmd_rd;
  logic                  a_result_full;
  logic [DWIDTH-1:0]     a_result_out;
  logic                  a_result_wr;

  modport master (
    input  h_cmd_empty, h_cmd_in, h_result_full, a_cmd_rd, a_result_out, a_result_wr,
    output h_cmd_rd, h_result_out, h_result_wr, a_cmd_empty, a_cmd_in, a_result_full
  );

  modport slave (
    output h_cmd_empty, h_cmd_in, h_result_full, a_cmd_rd, a_result_out, a_result_wr,
    input  h_cmd_rd, h_result_out, h_result_wr, a_cmd_empty, a_cmd_in, a_result_full
  );
endinterface

// File: rtl/l4_rr_arbiter.sv
// Combinational round-robin pick: first requester after last_owner, wrapping mod NCH.
module l4_rr_arbiter
  import l4_cmd_dispatch_pkg::*;
#(
  parameter int NCH    = 4,
  parameter int CHBITS = 2
) (
  input  logic [NCH-1:0]    req,
  input  logic [CHBITS-1:0] last_owner,
  output logic              gnt_valid,
  output logic [CHBITS-1:0] gnt_idx
);

  int c;

  // Walk from farthest to nearest so the nearest requester is the final winner.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    c         = 0;
    for (int k = NCH; k >= 1; k--) begin
      c = (int'(last_owner) + k) % NCH;
      if (req[CHBITS'(c)]) begin
        gnt_valid = 1'b1;
        gnt_idx   = CHBITS'(c);
      end
    end
  end

endmodule

// File: rtl/l4_cmd_dispatch.sv
// Shares one L4 accelerator among NCH host channels: one job per grant, round-robin,
// with per-channel completed-job counters and a sticky protocol-error flag.
module l4_cmd_dispatch
  import l4_cmd_dispatch_pkg::*;
#(
  parameter int          NCH      = 4,
  parameter int          CHBITS   = 2,
  parameter int          DWIDTH   = 32,
  parameter int          OPC_HI   = 31,
  parameter int          OPC_LO   = 28,
  parameter int unsigned END_OPC  = L4_END_OPC,
  parameter int          LAST_BIT = L4_LAST_BIT,
  parameter int          CNTBITS  = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  l4_cmd_dispatch_if.master      bus,
  output logic [CHBITS-1:0]      owner,
  output logic                   busy,
  output logic [1:0]             disp_state,
  output logic [NCH*CNTBITS-1:0] job_count,
  output logic                   err
);

  localparam int OPCW = OPC_HI - OPC_LO + 1;

  disp_state_e                    state_q, state_d;
  logic [CHBITS-1:0]              owner_q, owner_d;
  logic [CHBITS-1:0]              last_owner_q, last_owner_d;
  logic [NCH-1:0][CNTBITS-1:0]    jobs_q, jobs_d;
  logic                           err_q, err_d;

  logic                           gnt_valid;
  logic [CHBITS-1:0]              gnt_idx;
  logic [DWIDTH-1:0]              own_cmd;
  logic                           own_empty, own_full;
  logic                           cmd_xfer, res_xfer, res_last;

  l4_rr_arbiter #(.NCH(NCH), .CHBITS(CHBITS)) u_arb (
    .req        (~bus.h_cmd_empty),
    .last_owner (last_owner_q),
    .gnt_valid  (gnt_valid),
    .gnt_idx    (gnt_idx)
  );

  assign own_cmd   = bus.h_cmd_in[int'(owner_q)*DWIDTH +: DWIDTH];
  assign own_empty = bus.h_cmd_empty[owner_q];
  assign own_full  = bus.h_result_full[owner_q];
  assign res_last  = bus.a_result_out[LAST_BIT];

  always_comb begin
    state_d           = state_q;
    owner_d           = owner_q;
    last_owner_d      = last_owner_q;
    jobs_d            = jobs_q;
    err_d             = err_q;
    cmd_xfer          = 1'b0;
    res_xfer          = 1'b0;
    bus.a_cmd_empty   = 1'b1;
    bus.a_cmd_in      = '0;
    bus.a_result_full = 1'b1;
    bus.h_result_out  = '0;
    bus.h_cmd_rd      = '0;
    bus.h_result_wr   = '0;

    case (state_q)
      DISP_IDLE: begin
        // No owner to deliver to: any result push here is dropped and flagged.
        if (bus.a_result_wr) err_d = 1'b1;
        if (gnt_valid) begin
          owner_d = gnt_idx;
          state_d = DISP_STREAM;
        end
      end
      DISP_STREAM, DISP_WAIT_RES: begin
        bus.a_result_full            = own_full;
        bus.h_result_out             = bus.a_result_out;
        res_xfer                     = bus.a_result_wr && !own_full;
        bus.h_result_wr[owner_q]     = res_xfer;
        if (state_q == DISP_STREAM) begin
          bus.a_cmd_empty            = own_empty;
          bus.a_cmd_in               = own_cmd;
          cmd_xfer                   = bus.a_cmd_rd && !own_empty;
          bus.h_cmd_rd[owner_q]      = cmd_xfer;
          // A job cannot finish before its END command has gone out.
          if (res_xfer && res_last) err_d = 1'b1;
          if (cmd_xfer && own_cmd[OPC_HI:OPC_LO] == OPCW'(END_OPC))
            state_d = DISP_WAIT_RES;
        end else if (res_xfer && res_last) begin
          if (jobs_q[owner_q] != '1)
            jobs_d[owner_q] = jobs_q[owner_q] + CNTBITS'(1);
          last_owner_d = owner_q;
          state_d      = DISP_IDLE;
        end
      end
      default: state_d = DISP_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= DISP_IDLE;
      owner_q      <= '0;
      last_owner_q <= CHBITS'(NCH - 1);
      jobs_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      jobs_q       <= jobs_d;
      err_q        <= err_d;
    end
  end

  assign owner      = owner_q;
  assign busy       = (state_q == DISP_STREAM) || (state_q == DISP_WAIT_RES);
  assign disp_state = state_q;
  assign job_count  = jobs_q;
  assign err        = err_q;

endmodule

// File: tb/tb_l4_cmd_dispatch.sv
// Random multi-channel job traffic scored against a job-level round-robin model,
// plus directed error and async-reset scenarios.
module tb_l4_cmd_dispatch;
  localparam int NCH = 4, CHB = 2, DW = 32, CNTB = 16, TOTAL = 40;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  l4_cmd_dispatch_if #(.NCH(NCH), .DWIDTH(DW)) bus ();

  logic [CHB-1:0]       owner;
  logic                 busy, err;
  logic [1:0]           disp_state;
  logic [NCH*CNTB-1:0]  job_count;

  l4_cmd_dispatch #(
    .NCH(NCH), .CHBITS(CHB), .DWIDTH(DW), .OPC_HI(31), .OPC_LO(28),
    .END_OPC(15), .LAST_BIT(31), .CNTBITS(CNTB)
  ) dut (
    .clk(clk), .resetn(resetn), .bus(bus), .owner(owner), .busy(busy),
    .disp_state(disp_state), .job_count(job_count), .err(err)
  );

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  logic [DW-1:0] hq   [NCH][$];  // host command FIFOs (stimulus)
  logic [DW-1:0] expq [NCH][$];  // model copy of commands still owed to the accelerator
  logic [DW-1:0] rq   [NCH][$];  // host result FIFOs (captured)
  logic [DW-1:0] expr [NCH][$];  // results the model expects per channel
  logic [DW-1:0] resw [$];
  int            full_cnt [NCH];
  int            m_jobs   [NCH];

  logic          a_rd, a_wr;
  logic [DW-1:0] a_word;
  logic [NCH-1:0] s_cmd_rd, s_res_wr;
  logic          s_cmd_empty, s_res_full;
  logic [DW-1:0] s_cmd_in, s_res_out;

  task automatic drive();
    for (int i = 0; i < NCH; i++) begin
      bus.h_cmd_empty[i]          = (hq[i].size() == 0);
      bus.h_cmd_in[i*DW +: DW]    = (hq[i].size() != 0) ? hq[i][0] : '0;
      bus.h_result_full[i]        = (full_cnt[i] > 0);
    end
    bus.a_cmd_rd     = a_rd;
    bus.a_result_wr  = a_wr;
    bus.a_result_out = a_word;
  endtask

  task automatic pre();
    @(negedge clk);
    drive();
    #1;
    s_cmd_rd    = bus.h_cmd_rd;
    s_res_wr    = bus.h_result_wr;
    s_cmd_empty = bus.a_cmd_empty;
    s_res_full  = bus.a_result_full;
    s_cmd_in    = bus.a_cmd_in;
    s_res_out   = bus.h_result_out;
  endtask

  task automatic post();
    @(posedge clk);
    for (int i = 0; i < NCH; i++) begin
      if (s_cmd_rd[i] && hq[i].size() != 0) void'(hq[i].pop_front());
      if (s_res_wr[i] && !bus.h_result_full[i]) rq[i].push_back(s_res_out);
      if (full_cnt[i] > 0) full_cnt[i]--;
    end
    #1;
  endtask

  task automatic add_job(input int ch);
    logic [DW-1:0] w;
    int n;
    n = $urandom_range(0, 2);
    for (int j = 0; j <= n; j++) begin
      if (j == n) w = {4'hF, 28'($urandom)};
      else        w = {4'($urandom_range(0, 14)), 28'($urandom)};
      hq[ch].push_back(w);
      expq[ch].push_back(w);
    end
  endtask

  function automatic int rr_pick(input int last, input logic [NCH-1:0] req);
    for (int k = 1; k <= NCH; k++)
      if (req[(last + k) % NCH]) return (last + k) % NCH;
    return -1;
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_state"},   disp_state, 0);
    chk({tag, "_owner"},   owner, 0);
    chk({tag, "_busy"},    busy, 0);
    chk({tag, "_err"},     err, 0);
    chk({tag, "_jobs"},    job_count, 0);
    chk({tag, "_aempty"},  bus.a_cmd_empty, 1);
    chk({tag, "_afull"},   bus.a_result_full, 1);
    chk({tag, "_hrd"},     bus.h_cmd_rd, 0);
    chk({tag, "_hwr"},     bus.h_result_wr, 0);
    chk({tag, "_hout"},    bus.h_result_out, 0);
  endtask

  initial begin
    int ap, m_owner, m_last, jobs_done, jobs_added, cyc, exp_o, nres;
    bit prev_idle, was_idle, granted;
    logic [NCH-1:0] prev_req, oh;
    logic [DW-1:0] w;

    a_rd = 0; a_wr = 0; a_word = '0;
    for (int i = 0; i < NCH; i++) begin full_cnt[i] = 0; m_jobs[i] = 0; end
    drive();
    #1;
    chk_reset("rst");
    #20;
    @(negedge clk) resetn = 1'b1;

    // Result push with no owner: dropped, err set
    a_wr = 1; a_word = 32'h8000_00AA;
    pre();
    chk("idle_wr_drop", s_res_wr, 0);
    chk("idle_afull", s_res_full, 1);
    post();
    a_wr = 0;
    pre();
    chk("idle_err", err, 1);
    chk("idle_state", disp_state, 0);
    post();
    @(negedge clk) resetn = 1'b0;
    #1 chk("err_clear", err, 0);
    @(negedge clk) resetn = 1'b1;

    // Random jobs; channels 0,1,3 loaded from reset exercise first-round fairness
    add_job(0); add_job(1); add_job(3);
    jobs_added = 3; jobs_done = 0; m_last = NCH - 1; m_owner = 0;
    ap = 0; prev_idle = 0; prev_req = '0; cyc = 0;
    while (jobs_done < TOTAL && cyc < 20000) begin
      cyc++;
      a_rd = ($urandom % 4) != 0;
      a_wr = (ap == 2) && (($urandom % 3) != 0);
      a_word = (ap == 2) ? resw[0] : '0;
      if (($urandom % 8) == 0) full_cnt[$urandom % NCH] = $urandom_range(1, 5);
      pre();
      was_idle = 0;
      if (ap == 0) begin
        if (s_cmd_empty) begin
          was_idle = 1;
          chk("idle_state", disp_state, 0);
          chk("idle_cmd_rd", s_cmd_rd, 0);
          if (prev_idle && prev_req != 0) chk("grant_latency", s_cmd_empty, 0);
        end else begin
          exp_o = rr_pick(m_last, prev_req);
          chk("grant_owner", owner, exp_o);
          chk("grant_busy", busy, 1);
          m_owner = exp_o;
          ap = 1;
        end
      end
      oh = NCH'(1) << m_owner;
      if (ap == 1) begin
        chk("cmd_avail", s_cmd_empty, 0);
        chk("cmd_rd", s_cmd_rd, a_rd ? oh : '0);
        chk("stream_wr", s_res_wr, 0);
        if (a_rd && expq[m_owner].size() != 0) begin
          w = expq[m_owner].pop_front();
          chk("cmd_word", s_cmd_in, w);
          if (w[31:28] == 4'hF) begin
            nres = $urandom_range(1, 4);
            for (int j = 0; j < nres; j++)
              resw.push_back((j == nres - 1) ? ($urandom | 32'h8000_0000) : ($urandom & 32'h7FFF_FFFF));
            if (jobs_done == 1) full_cnt[m_owner] = 6;
            ap = 3;  // results start next cycle
          end
        end
      end else if (ap == 2) begin
        chk("blk_after_end", {s_cmd_empty, s_cmd_rd}, {1'b1, {NCH{1'b0}}});
        chk("res_full", s_res_full, full_cnt[m_owner] > 0);
        if (a_wr && full_cnt[m_owner] == 0) begin
          chk("res_wr", s_res_wr, oh);
          chk("res_out", s_res_out, a_word);
          expr[m_owner].push_back(a_word);
          void'(resw.pop_front());
          if (a_word[31]) begin
            m_jobs[m_owner]++;
            m_last = m_owner;
            jobs_done++;
            ap = 0;
          end
        end else begin
          chk("res_wr_hold", s_res_wr, 0);
        end
      end
      if (ap == 3) ap = 2;
      prev_req  = ~bus.h_cmd_empty;
      prev_idle = was_idle;
      post();
      if (jobs_added < TOTAL && ($urandom % 6) == 0) begin
        add_job($urandom % NCH);
        jobs_added++;
      end
    end
    chk("random_done", jobs_done, TOTAL);

    for (int i = 0; i < NCH; i++) begin
      chk("res_cnt", rq[i].size(), expr[i].size());
      for (int j = 0; j < rq[i].size() && j < expr[i].size(); j++)
        chk("res_fifo", rq[i][j], expr[i][j]);
      chk("job_count", job_count[i*CNTB +: CNTB], m_jobs[i]);
    end
    chk("no_err", err, 0);

    // LAST result while still streaming: forwarded, err set, state holds
    a_rd = 0; a_wr = 0;
    hq[1].push_back(32'h1000_0005);
    hq[1].push_back(32'hF000_0006);
    granted = 0;
    for (int k = 0; k < 10 && !granted; k++) begin
      pre();
      granted = !s_cmd_empty;
      post();
    end
    chk("dir_grant", granted, 1);
    chk("dir_owner", owner, 1);
    a_wr = 1; a_word = 32'h8000_0042;
    pre();
    chk("stream_last_fwd", s_res_wr, 4'b0010);
    chk("stream_last_word", s_res_out, 32'h8000_0042);
    post();
    a_wr = 0;
    pre();
    chk("stream_last_err", err, 1);
    chk("stream_last_state", disp_state, 1);

    // Async reset mid-STREAM, between clock edges
    a_rd = 1; a_wr = 1; a_word = 32'h0000_0077;
    drive();
    #1 resetn = 1'b0;
    #1 chk_reset("async_rst");
    @(negedge clk);
    resetn = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
